// File: rtl/opa_pkg.sv
// Shared types and helpers for output_port_arbiter.
package opa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam logic [7:0] PORT_BASE = 8'hF0;
  localparam logic [7:0] PORT_LAST = 8'hFF;

  // True when addr lies inside the output port bank window.
  function automatic logic in_port_window(input logic [7:0] addr);
    return (addr >= PORT_BASE) && (8'(addr - PORT_BASE) <= 8'(PORT_LAST - PORT_BASE));
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Requester-side write bus of the output port arbiter.
interface output_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_err;

  modport master (
    output req_valid, req_addr, req_data, req_lock,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_lock,
    output req_ready, req_err
  );

endinterface

// File: rtl/output_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid after last_grant.
module output_port_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_c,
  output logic                       any_c
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Walk the ring starting one past the previous winner.
  always_comb begin
    int unsigned idx;
    grant_c = '0;
    any_c   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      if (!any_c && valid[IDX_W'(idx)]) begin
        grant_c = IDX_W'(idx);
        any_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Round-robin arbiter sharing the output port bank write bus.
// Optional feature: define OPA_LOCK_EN to enable locked (repeated) grants.
module output_port_arbiter
  import opa_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.slave  bus,
  output logic                  write,
  output logic [7:0]            address,
  output logic [7:0]            data_out,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               write_q, write_d;
  logic [7:0]         address_q, address_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   pick_c;
  logic               any_c;
  logic [7:0]         sel_addr_c;
  logic [7:0]         sel_data_c;
  logic               sel_valid_c;
  logic               sel_lock_c;

`ifdef OPA_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX) + 1;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               hold_c;
`else
  logic               unused_lock_c;
  assign unused_lock_c = ^{sel_lock_c, sel_valid_c, 32'(LOCK_MAX)};
`endif

  output_port_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .valid      (bus.req_valid),
    .last_grant (last_grant_q),
    .grant_c    (pick_c),
    .any_c      (any_c)
  );

  // Select the bus fields of the currently granted requester.
  always_comb begin
    sel_addr_c  = '0;
    sel_data_c  = '0;
    sel_valid_c = 1'b0;
    sel_lock_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_addr_c  = bus.req_addr[8*i +: 8];
        sel_data_c  = bus.req_data[8*i +: 8];
        sel_valid_c = bus.req_valid[i];
        sel_lock_c  = bus.req_lock[i];
      end
    end
  end

`ifdef OPA_LOCK_EN
  // A locked requester keeps priority while it still has a write pending.
  assign hold_c = (lock_cnt_q != '0) && sel_valid_c;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ready_d      = '0;
    err_d        = '0;
    write_d      = 1'b0;
    address_d    = address_q;
    data_d       = data_q;
`ifdef OPA_LOCK_EN
    lock_cnt_d   = lock_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef OPA_LOCK_EN
        if (hold_c) begin
          ready_d = NUM_REQ'(1) << grant_q;
          state_d = ACK;
        end else begin
          if (lock_cnt_q != '0) begin
            lock_cnt_d   = '0;
            last_grant_d = grant_q;
          end
          if (any_c) begin
            grant_d = pick_c;
            ready_d = NUM_REQ'(1) << pick_c;
            state_d = ACK;
          end
        end
`else
        if (any_c) begin
          grant_d = pick_c;
          ready_d = NUM_REQ'(1) << pick_c;
          state_d = ACK;
        end
`endif
      end
      ACK: begin
        state_d = IDLE;
        if (in_port_window(sel_addr_c)) begin
          write_d   = 1'b1;
          address_d = sel_addr_c;
          data_d    = sel_data_c;
        end else begin
          err_d = NUM_REQ'(1) << grant_q;
        end
        last_grant_d = grant_q;
`ifdef OPA_LOCK_EN
        if (sel_lock_c && (lock_cnt_q < CNT_W'(LOCK_MAX - 1))) begin
          lock_cnt_d   = lock_cnt_q + CNT_W'(1);
          last_grant_d = last_grant_q;
        end else begin
          lock_cnt_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      ready_q      <= '0;
      err_q        <= '0;
      write_q      <= 1'b0;
      address_q    <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
`ifdef OPA_LOCK_EN
      lock_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      write_q      <= write_d;
      address_q    <= address_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
`ifdef OPA_LOCK_EN
      lock_cnt_q   <= lock_cnt_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.req_err   = err_q;
  assign write         = write_q;
  assign address       = address_q;
  assign data_out      = data_q;
  assign busy          = busy_q;

endmodule
